adder_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one registered 16-bit ripple-carry adder among NREQ requesters.
- Accepts operand triples (a, b, cin) over a valid/ready handshake and drives them to the shared adder.
- Tracks in-flight operations through the adder's fixed latency and returns each result with its requester ID through a credit-protected response FIFO.
- Sits between client blocks and the adder instance; the adder itself is external.

---
 rtl/adder_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin front end for one shared, externally registered adder.
// Issues one operand triple per cycle and returns results in acceptance order.
module adder_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 16,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = $clog2(FIFO_DEPTH + ADD_LAT + 1);
  localparam int EW = ID_W + 1 + WIDTH;

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; requesters hold valid and data until then, and the response side pops
  // the FIFO head when rsp_valid && rsp_ready.

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADD_LAT-1:0] pv_q, pv_d;
  logic [ID_W-1:0]    pid_q [ADD_LAT];
  logic [ID_W-1:0]    pid_d [ADD_LAT];
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [EW-1:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [UW-1:0]      inflight_cnt;
  logic [UW-1:0]      used;
  logic               issue_ok;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               found;
  int                 idx;
  logic               accept;
  logic               push;
  logic               pop;
  logic [EW-1:0]      head;

  // Credit counts only registered occupancy, so a pop frees a slot next cycle.
  assign inflight_cnt = UW'($countones(pv_q));
  assign used         = UW'(cnt_q) + inflight_cnt;
  assign issue_ok     = used < UW'(FIFO_DEPTH);

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (found && issue_ok && !reset) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (accept) begin
      add_a   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
      add_b   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
      add_cin = req_cin[gnt_idx];
    end
  end

  // Pointer and in-flight shift register mirror the adder's fixed latency.
  always_comb begin
    ptr_d = accept ? gnt_idx : ptr_q;
    pv_d  = '0;
    pid_d = pid_q;
    pv_d[0]  = accept;
    pid_d[0] = gnt_idx;
    for (int s = 1; s < ADD_LAT; s++) begin
      pv_d[s]  = pv_q[s-1];
      pid_d[s] = pid_q[s-1];
    end
  end

  assign push      = pv_q[ADD_LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = {pid_q[ADD_LAT-1], add_cout, add_sum};
      wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= ID_W'(NREQ - 1);
      pv_q  <= '0;
      for (int s = 0; s < ADD_LAT; s++) pid_q[s] <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      pv_q  <= pv_d;
      pid_q <= pid_d;
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && cnt_q == CW'(FIFO_DEPTH)));
  end

  assign head     = mem_q[rd_q];
  assign rsp_id   = rsp_valid ? head[EW-1 -: ID_W] : '0;
  assign rsp_cout = rsp_valid ? head[WIDTH] : 1'b0;
  assign rsp_sum  = rsp_valid ? head[WIDTH-1:0] : '0;
  assign busy     = (|pv_q) || (cnt_q != '0);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: models the external two-stage adder and
// scoreboards every accepted operation against its response.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 1 + W;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [W-1:0]      add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              rsp_valid, rsp_ready, rsp_cout, busy;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .ADD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external shared adder: input register then output register
  logic [W-1:0] ar, br;
  logic         cr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ar <= '0; br <= '0; cr <= 1'b0;
      add_sum <= '0; add_cout <= 1'b0;
    end else begin
      ar <= add_a; br <= add_b; cr <= add_cin;
      {add_cout, add_sum} <= {1'b0, ar} + {1'b0, br} + {{W{1'b0}}, cr};
    end
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            gnt_q[$];
  int            acc_cyc_q[$];
  int            pop_cyc_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [NREQ-1:0] last_acc = '0;
  logic          last_pop  = 1'b0;
  logic          last_busy = 1'b0;
  logic [EW-1:0] last_rsp  = '0;
  int            stale_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: observe at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic [W:0]      s;
    int              gi;
    @(negedge clk);
    acc       = req_valid & req_ready;
    last_acc  = acc;
    last_pop  = 1'b0;
    last_busy = busy;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (acc != '0) begin
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (acc[i]) gi = i;
        check("add_a", 32'(add_a), 32'(req_a[gi*W +: W]));
        check("add_b", 32'(add_b), 32'(req_b[gi*W +: W]));
        check("add_cin", 32'(add_cin), 32'(req_cin[gi]));
        s = {1'b0, req_a[gi*W +: W]} + {1'b0, req_b[gi*W +: W]} + {{W{1'b0}}, req_cin[gi]};
        exp_q.push_back({IDW'(gi), s});
        gnt_q.push_back(gi);
        acc_cyc_q.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        last_pop = 1'b1;
        last_rsp = {rsp_id, rsp_cout, rsp_sum};
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp", 32'({rsp_id, rsp_cout, rsp_sum}), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic load(input int i);
    req_a[i*W +: W] = W'($urandom_range(0, 16'hFFFF));
    req_b[i*W +: W] = W'($urandom_range(0, 16'hFFFF));
    req_cin[i]      = 1'($urandom_range(0, 1));
  endtask

  task automatic run_stream(input logic [NREQ-1:0] mask, input int n);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i] && !req_valid[i]) load(i);
      req_valid[i] = mask[i];
    end
    repeat (n) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (mask[i] && last_acc[i]) load(i);
    end
  endtask

  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic done;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
    req_valid[i]    = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      if (last_acc[i]) done = 1'b1;
    end
    req_valid[i] = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else tick();
    end
    check("drain", 32'(done), 32'd1);
  endtask

  initial begin
    int s, k, pa, aa;
    logic found;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;

    // reset state, with a requester already asserting valid
    repeat (3) @(posedge clk);
    req_valid = 4'b0001;
    req_a[W-1:0] = 16'h1234;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    // single op with latency and busy tracking
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (last_pop) found = 1'b1;
    end
    check("single_pop_seen", 32'(found), 32'd1);
    check("single_rsp", 32'(last_rsp), 32'({2'd0, 1'b1, 16'h0000}));
    if (acc_cyc_q.size() > 0 && pop_cyc_q.size() > 0)
      check("single_latency", 32'(pop_cyc_q[$] - acc_cyc_q[$]), 32'd3);
    check("busy_at_pop", 32'(last_busy), 32'd1);
    tick();
    check("busy_after_pop", 32'(last_busy), 32'd0);

    // round robin, all requesters continuously valid
    s = gnt_q.size();
    run_stream(4'b1111, 12);
    req_valid = '0;
    check("rr_accepts", 32'(gnt_q.size() - s), 32'd12);
    for (int i = s + 1; i < gnt_q.size(); i++)
      check("rr_order", 32'(gnt_q[i]), 32'((gnt_q[i-1] + 1) % NREQ));
    wait_idle();

    // backpressure: credit stops issue at FIFO_DEPTH outstanding
    rsp_ready = 1'b0;
    s = gnt_q.size();
    run_stream(4'b0010, 10);
    check("bp_accepts", 32'(gnt_q.size() - s), 32'd4);
    check("bp_ready_low", 32'(req_ready[1]), 32'd0);
    check("bp_fifo_full_valid", 32'(rsp_valid), 32'd1);
    pa = pop_cyc_q.size();
    aa = acc_cyc_q.size();
    rsp_ready = 1'b1;
    run_stream(4'b0010, 6);
    req_valid = '0;
    if (pop_cyc_q.size() > pa && acc_cyc_q.size() > aa)
      check("bp_resume", 32'(acc_cyc_q[aa]), 32'(pop_cyc_q[pa] + 1));
    else
      check("bp_resume_seen", 32'd0, 32'd1);
    wait_idle();

    // fairness: req0 joins a 2/3 stream
    run_stream(4'b1100, 5);
    s = gnt_q.size();
    run_stream(4'b1101, 8);
    req_valid = '0;
    k = -1;
    for (int i = s; i < gnt_q.size(); i++) if (k < 0 && gnt_q[i] == 0) k = i;
    check("fair_req0_granted", 32'(k >= 0), 32'd1);
    if (k > 0) begin
      check("fair_prev_is_3", 32'(gnt_q[k-1]), 32'd3);
      check("fair_wait_bound", 32'(k - s <= NREQ - 1), 32'd1);
    end
    wait_idle();

    // reset with work in flight and queued
    rsp_ready = 1'b0;
    run_stream(4'b0010, 5);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    check("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_add_a", 32'(add_a), 32'd0);
    tick();
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    reset = 1'b0;
    stale_seen = 0;
    repeat (6) begin
      tick();
      if (rsp_valid) stale_seen++;
    end
    check("no_stale", 32'(stale_seen), 32'd0);
    req_a[0*W +: W] = 16'h0011; req_b[0*W +: W] = 16'h0022; req_cin[0] = 1'b0;
    req_a[2*W +: W] = 16'h0100; req_b[2*W +: W] = 16'h0200; req_cin[2] = 1'b1;
    req_valid = 4'b0101;
    tick();
    check("post_rst_first_grant", 32'(last_acc), 32'b0001);
    req_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (last_acc[2]) found = 1'b1;
    end
    req_valid = '0;
    check("post_rst_req2", 32'(found), 32'd1);
    wait_idle();

    // carry-in path
    send(3, 16'h7FFF, 16'h0000, 1'b1);
    wait_idle();
    check("cin_rsp", 32'(last_rsp), 32'({2'd3, 1'b0, 16'h8000}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
